// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the pipeline control logic.
//   lc3b_word       : 16-bit machine word (PCs, branch targets)
//   lc3b_reg        : 3-bit architectural register index
//   lc3b_pctl_state : pipeline controller FSM state
//   PCTL_CNT_WIDTH  : default width of the performance counters
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_PEND = 1'b1
  } lc3b_pctl_state;

  localparam int PCTL_CNT_WIDTH = 16;

endpackage

// File: rtl/pipe_ctrl_unit_sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   clr   : synchronous clear (takes priority over inc)
//   inc   : increment enable; the count sticks at all-ones
//   count : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Stall/flush controller for the 5-stage LC-3b pipeline.
// Inputs : clk, reset (sync, active-high), imem_read/imem_resp (fetch),
//          dmem_req/dmem_resp (MEM data access), ID source operands,
//          EXE load info, MEM branch resolution (mem_br_taken/target).
// Outputs: load_pc, pc_redirect, pc_target (PC control), per-register
//          stall/flush strobes, and two saturating debug counters
//          (dstall_count: dmem freeze cycles, lu_count: load-use bubbles).
// All control outputs are combinational; only the FSM state, the pending
// redirect target and the counters are registered.
module pipe_ctrl_unit
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = PCTL_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 imem_read,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 id_valid,
  input  logic [2:0]           id_sr1,
  input  logic                 id_sr1_used,
  input  logic [2:0]           id_sr2,
  input  logic                 id_sr2_used,
  input  logic                 exe_valid,
  input  logic                 exe_is_load,
  input  logic [2:0]           exe_dest,
  input  logic                 mem_br_taken,
  input  logic [15:0]          mem_br_target,
  output logic                 load_pc,
  output logic                 pc_redirect,
  output logic [15:0]          pc_target,
  output logic                 stall_if_id,
  output logic                 stall_id_exe,
  output logic                 stall_exe_mem,
  output logic                 stall_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_exe,
  output logic                 flush_exe_mem,
  output logic [CNT_WIDTH-1:0] dstall_count,
  output logic [CNT_WIDTH-1:0] lu_count
);

  lc3b_pctl_state state_reg, state_next;
  lc3b_word       redir_reg, redir_next;

  logic iw, dw, lu;
  logic dstall_inc, lu_inc;

  assign iw = imem_read & ~imem_resp;
  assign dw = dmem_req & ~dmem_resp;
  assign lu = exe_valid & exe_is_load & id_valid &
              ((id_sr1_used & (id_sr1 == lc3b_reg'(exe_dest))) |
               (id_sr2_used & (id_sr2 == lc3b_reg'(exe_dest))));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      redir_reg <= '0;
    end else begin
      state_reg <= state_next;
      redir_reg <= redir_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    redir_next    = redir_reg;
    load_pc       = 1'b1;
    pc_redirect   = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_exe  = 1'b0;
    stall_exe_mem = 1'b0;
    stall_mem_wb  = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_exe  = 1'b0;
    flush_exe_mem = 1'b0;
    dstall_inc    = 1'b0;
    lu_inc        = 1'b0;
    // Target mux follows the state alone so the PC mux path stays short.
    pc_target     = (state_reg == REDIR_PEND) ? redir_reg : mem_br_target;

    if (reset) begin
      load_pc       = 1'b0;
      flush_if_id   = 1'b1;
      flush_id_exe  = 1'b1;
      flush_exe_mem = 1'b1;
      state_next    = RUN;
      redir_next    = '0;
    end else if (dw) begin
      // Whole pipe frozen; a branch sitting in MEM is retried once unfrozen.
      load_pc       = 1'b0;
      stall_if_id   = 1'b1;
      stall_id_exe  = 1'b1;
      stall_exe_mem = 1'b1;
      stall_mem_wb  = 1'b1;
      dstall_inc    = 1'b1;
    end else if (mem_br_taken && !iw && (state_reg == RUN)) begin
      pc_redirect   = 1'b1;
      flush_if_id   = 1'b1;
      flush_id_exe  = 1'b1;
      flush_exe_mem = 1'b1;
    end else if (mem_br_taken && iw) begin
      // Fetch address must not move while imem is busy: park the target.
      load_pc       = 1'b0;
      flush_if_id   = 1'b1;
      flush_id_exe  = 1'b1;
      flush_exe_mem = 1'b1;
      redir_next    = mem_br_target;
      state_next    = REDIR_PEND;
    end else if ((state_reg == REDIR_PEND) && !iw) begin
      // The instruction arriving now is wrong-path; drop it and redirect.
      pc_redirect   = 1'b1;
      flush_if_id   = 1'b1;
      state_next    = RUN;
    end else if (lu) begin
      // Bubble into EXE; any imem response this cycle is dropped and the
      // same PC refetched because load_pc is low.
      load_pc       = 1'b0;
      stall_if_id   = 1'b1;
      flush_id_exe  = 1'b1;
      lu_inc        = 1'b1;
    end else if (iw) begin
      load_pc       = 1'b0;
      flush_if_id   = 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_dstall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (dstall_inc),
    .count (dstall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_lu_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (lu_inc),
    .count (lu_count)
  );

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: a driver issues stimulus and pushes
// the reference model's expected outputs; a monitor pops and compares them
// mid-cycle.
module tb_pipe_ctrl_unit;

  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_read, imem_resp, dmem_req, dmem_resp;
  logic        id_valid, id_sr1_used, id_sr2_used;
  logic [2:0]  id_sr1, id_sr2, exe_dest;
  logic        exe_valid, exe_is_load, mem_br_taken;
  logic [15:0] mem_br_target;
  logic        load_pc, pc_redirect;
  logic [15:0] pc_target;
  logic        stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb;
  logic        flush_if_id, flush_id_exe, flush_exe_mem;
  logic [CW-1:0] dstall_count, lu_count;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_valid(id_valid), .id_sr1(id_sr1), .id_sr1_used(id_sr1_used),
    .id_sr2(id_sr2), .id_sr2_used(id_sr2_used),
    .exe_valid(exe_valid), .exe_is_load(exe_is_load), .exe_dest(exe_dest),
    .mem_br_taken(mem_br_taken), .mem_br_target(mem_br_target),
    .load_pc(load_pc), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .stall_if_id(stall_if_id), .stall_id_exe(stall_id_exe),
    .stall_exe_mem(stall_exe_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
    .flush_exe_mem(flush_exe_mem),
    .dstall_count(dstall_count), .lu_count(lu_count)
  );

  typedef struct packed {
    logic        load_pc;
    logic        pc_redirect;
    logic [15:0] pc_target;
    logic [3:0]  stall;   // {if_id, id_exe, exe_mem, mem_wb}
    logic [2:0]  flush;   // {if_id, id_exe, exe_mem}
    logic [15:0] ds;
    logic [15:0] lu;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;
  bit   verbose  = 1'b1;

  // Reference model state: is a redirect owed, to where, and counter values.
  bit          m_pend;
  logic [15:0] m_redir;
  int          m_lu, m_ds;

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Expected outputs for the current inputs, plus the model state after
  // the coming clock edge.
  function automatic void model(output exp_t e, output bit n_pend,
                                output logic [15:0] n_redir,
                                output int n_lu, output int n_ds);
    bit fetch_wait = imem_read && !imem_resp;
    bit data_wait  = dmem_req && !dmem_resp;
    bit uses_load  = exe_valid && exe_is_load && id_valid &&
                     ((id_sr1_used && id_sr1 == exe_dest) ||
                      (id_sr2_used && id_sr2 == exe_dest));
    e = '0;
    e.load_pc   = 1'b1;
    e.pc_target = m_pend ? m_redir : mem_br_target;
    e.ds        = 16'(m_ds);
    e.lu        = 16'(m_lu);
    n_pend = m_pend; n_redir = m_redir; n_lu = m_lu; n_ds = m_ds;
    if (reset) begin
      e.load_pc = 1'b0; e.flush = 3'b111;
      n_pend = 1'b0; n_redir = '0; n_lu = 0; n_ds = 0;
    end else if (data_wait) begin
      e.load_pc = 1'b0; e.stall = 4'b1111; n_ds = sat_inc(m_ds);
    end else if (mem_br_taken && !fetch_wait && !m_pend) begin
      e.pc_redirect = 1'b1; e.flush = 3'b111;
    end else if (mem_br_taken && fetch_wait) begin
      e.load_pc = 1'b0; e.flush = 3'b111;
      n_pend = 1'b1; n_redir = mem_br_target;
    end else if (m_pend && !fetch_wait) begin
      e.pc_redirect = 1'b1; e.flush = 3'b100; n_pend = 1'b0;
    end else if (uses_load) begin
      e.load_pc = 1'b0; e.stall = 4'b1000; e.flush = 3'b010;
      n_lu = sat_inc(m_lu);
    end else if (fetch_wait) begin
      e.load_pc = 1'b0; e.flush = 3'b100;
    end
  endfunction

  task automatic issue();
    exp_t        e;
    bit          np;
    logic [15:0] nr;
    int          nl, nd;
    model(e, np, nr, nl, nd);
    exp_q.push_back(e);
    @(posedge clk);
    m_pend = np; m_redir = nr; m_lu = nl; m_ds = nd;
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic clear_inputs();
    reset = 0; imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    id_valid = 0; id_sr1 = 0; id_sr1_used = 0; id_sr2 = 0; id_sr2_used = 0;
    exe_valid = 0; exe_is_load = 0; exe_dest = 0;
    mem_br_taken = 0; mem_br_target = 0;
  endtask

  task automatic do_reset(input int n);
    clear_inputs();
    reset = 1;
    repeat (n) issue();
    reset = 0;
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle with the oldest
  // expectation.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.load_pc = load_pc; a.pc_redirect = pc_redirect;
        a.pc_target = pc_target;
        a.stall = {stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb};
        a.flush = {flush_if_id, flush_id_exe, flush_exe_mem};
        a.ds = dstall_count; a.lu = lu_count;
        n_checks++;
        n_txn++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL outputs txn=%0d actual=%h required=%h", n_txn, a, e);
        end else if (verbose) begin
          $display("txn %0d: lpc=%b red=%b tgt=%h st=%b fl=%b ds=%0d lu=%0d",
                   n_txn, a.load_pc, a.pc_redirect, a.pc_target, a.stall,
                   a.flush, a.ds, a.lu);
        end
      end
    end
  end

  initial begin
    int drain;
    m_pend = 0; m_redir = 0; m_lu = 0; m_ds = 0;
    clear_inputs();
    @(posedge clk); #1;

    // Reset then idle.
    do_reset(2);
    chk("reset_dstall", 16'(dstall_count), 16'h0);
    chk("reset_lu", 16'(lu_count), 16'h0);
    issue(); issue();

    // Load-use hit, then same operands without sr1 in use.
    exe_valid = 1; exe_is_load = 1; exe_dest = 3;
    id_valid = 1; id_sr1 = 3; id_sr1_used = 1;
    #1 chk("lu_stall_if_id", 16'(stall_if_id), 16'h1);
    chk("lu_load_pc", 16'(load_pc), 16'h0);
    issue();
    id_sr1_used = 0;
    #1 chk("lu_no_bubble", 16'(flush_id_exe), 16'h0);
    issue();
    chk("lu_count_one", 16'(lu_count), 16'h1);

    // dmem wait 5 cycles, response in the 5th, branch ignored meanwhile.
    do_reset(1);
    dmem_req = 1; mem_br_taken = 1; mem_br_target = 16'h5555;
    repeat (4) issue();
    dmem_resp = 1; mem_br_taken = 0;
    issue();
    clear_inputs();
    chk("dstall_count_four", 16'(dstall_count), 16'h4);

    // Branch with no fetch outstanding.
    mem_br_taken = 1; mem_br_target = 16'h3040;
    #1 chk("br_pc_target", pc_target, 16'h3040);
    chk("br_pc_redirect", 16'(pc_redirect), 16'h1);
    issue();
    clear_inputs(); issue();

    // Branch while fetch outstanding; response three cycles later.
    imem_read = 1; mem_br_taken = 1; mem_br_target = 16'h1200;
    issue();
    mem_br_taken = 0; mem_br_target = 16'h0BAD;
    issue(); issue();
    imem_resp = 1;
    #1 chk("pend_pc_target", pc_target, 16'h1200);
    chk("pend_redirect", 16'(pc_redirect), 16'h1);
    issue();
    clear_inputs(); issue();

    // lu_count saturation.
    verbose = 0;
    exe_valid = 1; exe_is_load = 1; exe_dest = 5;
    id_valid = 1; id_sr2 = 5; id_sr2_used = 1;
    repeat (CMAX + 4) issue();
    verbose = 1;
    chk("lu_saturated", 16'(lu_count), 16'hFFFF);
    clear_inputs(); issue();

    // Reset while a redirect is pending discards it.
    imem_read = 1; mem_br_taken = 1; mem_br_target = 16'h4444;
    issue();
    mem_br_taken = 0; issue();
    do_reset(1);
    imem_read = 1; imem_resp = 1;
    #1 chk("reset_drops_redirect", 16'(pc_redirect), 16'h0);
    issue();
    clear_inputs(); issue();

    // Randomized traffic.
    verbose = 0;
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      imem_read     = ($urandom_range(0, 3) != 0);
      imem_resp     = ($urandom_range(0, 2) == 0);
      dmem_req      = ($urandom_range(0, 3) == 0);
      dmem_resp     = ($urandom_range(0, 1) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_sr1        = 3'($urandom_range(0, 7));
      id_sr1_used   = ($urandom_range(0, 1) == 0);
      id_sr2        = 3'($urandom_range(0, 7));
      id_sr2_used   = ($urandom_range(0, 1) == 0);
      exe_valid     = ($urandom_range(0, 3) != 0);
      exe_is_load   = ($urandom_range(0, 1) == 0);
      exe_dest      = 3'($urandom_range(0, 7));
      mem_br_taken  = ($urandom_range(0, 5) == 0);
      mem_br_target = 16'($urandom);
      issue();
    end
    verbose = 1;
    clear_inputs();

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
